uart_rx_controller: RTL and testbench

Receive-side sequencer for the UART. Synchronizes the serial line and detects the start bit. Times mid-bit samples with an internal baud counter, shifts data bits in LSB-first, and checks the stop bit. Completed bytes are presented on a one-entry valid/ready output buffer, with framing-error and overrun reporting, to the downstream consumer (FIFO or command decoder).

---
 rtl/uart_rx_controller.sv | 128 ++++++++++++
 tb/tb_uart_rx_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: two-flop line synchronizer, start/data/stop FSM with
// mid-bit sampling, and a one-entry valid/ready output buffer with error pulses.
module uart_rx_controller #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 framing_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state;
   state_t               state_next;
   logic                 rx_p0;
   logic                 rx_s;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     idx;
   logic [DATA_BITS-1:0] shift;
   logic                 cnt_clr;
   logic                 shift_en;
   logic                 frame_good;
   logic                 frame_bad;

   // Stage p0/p1: synchronizer, reset to idle-high so no false start on release
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_p0 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_s  <= rx_p0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      shift_en   = 1'b0;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (!rx_s) state_next = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_clr    = 1'b1;
               state_next = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (idx == IDX_LAST) state_next = STOP;
            end
         end
         STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_clr    = 1'b1;
               frame_good = rx_s;
               frame_bad  = !rx_s;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Baud counter, bit index and LSB-first shift register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         if (cnt_clr) cnt <= '0;
         else         cnt <= cnt + 1'b1;
         if (shift_en) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
         end else if (state != DATA) begin
            idx <= '0;
         end
      end
   end

   // Output buffer: a draining consumer frees the slot in the same cycle a frame lands
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_out    <= '0;
         data_valid  <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         framing_err <= frame_bad;
         overrun     <= frame_good && data_valid && !data_ready;
         if (frame_good && (!data_valid || data_ready)) begin
            data_out   <= shift;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: frames driven bit by bit on rx, outputs
// observed by a negedge monitor and checked with immediate assertions.
module tb_uart_rx_controller;
   localparam int CPB = 16;
   localparam int NB  = 8;
   // data_valid first seen high at the negedge following edge e154, i.e. 155 edges
   // after the cycle in which rx is driven low.
   localparam int RISE_OFS = 155;

   logic          clock;
   logic          reset;
   logic          rx;
   logic [NB-1:0] data_out;
   logic          data_valid;
   logic          data_ready;
   logic          framing_err;
   logic          overrun;
   logic          busy;

   int checks = 0;
   int errors = 0;

   int            cyc = 0;
   int            frame_start = 0;
   int            dv_rises = 0, dv_high = 0, dv_rise_cyc = 0;
   logic [NB-1:0] dv_rise_data = '0;
   int            fe_cnt = 0, fe_cyc = 0, ov_cnt = 0, ov_cyc = 0, both_cnt = 0;
   int            busy_high = 0, busy_fall_cyc = 0;
   logic          dv_prev = 1'b0, busy_prev = 1'b0;

   int fe0, ov0, dv0, dh0, bh0;

   uart_rx_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB)) dut (
      .clock      (clock),
      .reset      (reset),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .framing_err(framing_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (data_valid && !dv_prev) begin
         dv_rises     <= dv_rises + 1;
         dv_rise_cyc  <= cyc;
         dv_rise_data <= data_out;
      end
      if (data_valid) dv_high <= dv_high + 1;
      if (framing_err) begin
         fe_cnt <= fe_cnt + 1;
         fe_cyc <= cyc;
      end
      if (overrun) begin
         ov_cnt <= ov_cnt + 1;
         ov_cyc <= cyc;
      end
      if (framing_err && overrun) both_cnt <= both_cnt + 1;
      if (busy) busy_high <= busy_high + 1;
      if (!busy && busy_prev) busy_fall_cyc <= cyc;
      dv_prev   <= data_valid;
      busy_prev <= busy;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Drives one 10-bit frame starting now (just after an edge). ready_at pulses
   // data_ready for one cycle at that frame cycle; abort_at asserts reset and returns.
   task automatic send_frame(input logic [NB-1:0] b, input logic stop_bit,
                             input int ready_at, input int abort_at);
      frame_start = cyc;
      for (int i = 0; i < (NB + 2) * CPB; i++) begin
         if (i < CPB)                rx = 1'b0;
         else if (i < (NB + 1) * CPB) rx = b[(i - CPB) / CPB];
         else                        rx = stop_bit;
         if (ready_at >= 0) data_ready = (i == ready_at);
         if (i == abort_at) begin
            reset = 1'b0;
            rx    = 1'b1;
            return;
         end
         tick(1);
      end
      rx = 1'b1;
      if (ready_at >= 0) data_ready = 1'b0;
   endtask

   task automatic snap();
      fe0 = fe_cnt; ov0 = ov_cnt; dv0 = dv_rises; dh0 = dv_high; bh0 = busy_high;
   endtask

   initial begin
      reset = 1'b0; rx = 1'b1; data_ready = 1'b0;
      tick(3);
      check("rst_data_out", data_out, 0);
      check("rst_valid", data_valid, 0);
      check("rst_ferr", framing_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      reset = 1'b1;
      tick(5);

      // Good frame 0x55, consumer always ready
      data_ready = 1'b1;
      snap();
      send_frame(8'h55, 1'b1, -1, -1);
      tick(20);
      check("f55_rise_cyc", dv_rise_cyc, frame_start + RISE_OFS);
      check("f55_data", dv_rise_data, 8'h55);
      check("f55_valid_len", dv_high - dh0, 1);
      check("f55_busy_fall", busy_fall_cyc, frame_start + RISE_OFS);
      check("f55_held", data_out, 8'h55);

      // Bad stop bit on 0xA3, then good 0x3C
      snap();
      send_frame(8'hA3, 1'b0, -1, -1);
      tick(20);
      check("fa3_ferr_cnt", fe_cnt - fe0, 1);
      check("fa3_ferr_cyc", fe_cyc, frame_start + RISE_OFS);
      check("fa3_no_valid", dv_rises - dv0, 0);
      check("fa3_no_ovr", ov_cnt - ov0, 0);
      send_frame(8'h3C, 1'b1, -1, -1);
      tick(20);
      check("f3c_data", dv_rise_data, 8'h3C);
      check("f3c_rise_cyc", dv_rise_cyc, frame_start + RISE_OFS);

      // Three-cycle glitch: START for 8 cycles then back to IDLE
      snap();
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(30);
      check("gl_busy_cycles", busy_high - bh0, 8);
      check("gl_no_valid", dv_rises - dv0, 0);
      check("gl_no_ferr", fe_cnt - fe0, 0);
      check("gl_no_ovr", ov_cnt - ov0, 0);

      // Overrun: 0x12 buffered, 0x34 dropped
      data_ready = 1'b0;
      snap();
      send_frame(8'h12, 1'b1, -1, -1);
      tick(20);
      check("ov_first", dv_rise_data, 8'h12);
      send_frame(8'h34, 1'b1, -1, -1);
      tick(20);
      check("ov_cnt", ov_cnt - ov0, 1);
      check("ov_cyc", ov_cyc, frame_start + RISE_OFS);
      check("ov_held_data", data_out, 8'h12);
      check("ov_held_valid", data_valid, 1);
      check("ov_no_ferr", fe_cnt - fe0, 0);
      data_ready = 1'b1;
      tick(1);
      data_ready = 1'b0;
      check("ov_drained", data_valid, 0);
      check("ov_data_kept", data_out, 8'h12);

      // Consumer drains on exactly the completing edge of 0x9E
      snap();
      send_frame(8'h12, 1'b1, -1, -1);
      tick(20);
      send_frame(8'h9E, 1'b1, RISE_OFS - 1, -1);
      tick(20);
      check("rdy_no_ovr", ov_cnt - ov0, 0);
      check("rdy_data", data_out, 8'h9E);
      check("rdy_valid", data_valid, 1);
      check("rdy_one_rise", dv_rises - dv0, 1);
      data_ready = 1'b1;
      tick(1);
      data_ready = 1'b0;
      check("rdy_drained", data_valid, 0);

      // Reset mid DATA bit 4 of 0xF0
      snap();
      send_frame(8'hF0, 1'b1, -1, 88);
      #1;
      check("mr_data_out", data_out, 0);
      check("mr_valid", data_valid, 0);
      check("mr_busy", busy, 0);
      check("mr_ferr", framing_err, 0);
      tick(3);
      reset = 1'b1;
      tick(30);
      check("mr_no_ferr", fe_cnt - fe0, 0);
      check("mr_no_ovr", ov_cnt - ov0, 0);
      check("mr_no_valid", dv_rises - dv0, 0);
      data_ready = 1'b1;
      send_frame(8'h81, 1'b1, -1, -1);
      tick(20);
      check("mr_next_data", dv_rise_data, 8'h81);
      check("mr_next_cyc", dv_rise_cyc, frame_start + RISE_OFS);

      check("never_both", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
